// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: latches one instruction per handshake and
// sequences DECODE/EXEC/MEM/WB, driving ALU, register-file, memory and PC controls.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] alu_result,
  output logic [2:0]  alu_op,
  output logic        alu_a_zero,
  output logic        alu_b_imm,
  output logic [31:0] imm_ext,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic        rf_wsel,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t      state, next_state;
  logic [31:0] ir;

  logic [5:0]  opcode, funct;
  logic [4:0]  dest;
  logic        is_nop, is_r, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_bad;
  logic        r_legal;
  logic [2:0]  r_op, ex_op;
  logic        ex_a_zero, ex_b_imm;

  // Instruction decode from the latched IR
  always_comb begin
    opcode  = ir[31:26];
    funct   = ir[5:0];
    r_legal = 1'b1;
    r_op    = 3'd0;
    case (funct)
      6'h20:   r_op = 3'd1;
      6'h22:   r_op = 3'd2;
      6'h24:   r_op = 3'd6;
      6'h25:   r_op = 3'd3;
      6'h2a:   r_op = 3'd4;
      6'h2b:   r_op = 3'd5;
      default: r_legal = 1'b0;
    endcase
    is_nop = (ir == 32'd0);
    is_r   = (opcode == OP_RTYPE) && !is_nop && r_legal;
    is_ori = (opcode == OP_ORI);
    is_lui = (opcode == OP_LUI);
    is_lw  = (opcode == OP_LW);
    is_sw  = (opcode == OP_SW);
    is_beq = (opcode == OP_BEQ);
    is_j   = (opcode == OP_J);
    is_bad = !(is_nop || is_r || is_ori || is_lui || is_lw || is_sw || is_beq || is_j);
    dest   = is_r ? ir[15:11] : ir[20:16];

    ex_op     = 3'd0;
    ex_a_zero = 1'b0;
    ex_b_imm  = 1'b0;
    if (is_r) begin
      ex_op = r_op;
    end else if (is_ori || is_lui) begin
      ex_op     = 3'd3;
      ex_b_imm  = 1'b1;
      ex_a_zero = is_lui;
    end else if (is_lw || is_sw) begin
      ex_op    = 3'd1;
      ex_b_imm = 1'b1;
    end else if (is_beq) begin
      ex_op = 3'd2;
    end

    if (is_lui)      imm_ext = {ir[15:0], 16'h0000};
    else if (is_ori) imm_ext = {16'h0000, ir[15:0]};
    else             imm_ext = {{16{ir[15]}}, ir[15:0]};
  end

  // Moore outputs and next state; only beq's pc_sel looks at alu_result
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    alu_op      = 3'd0;
    alu_a_zero  = 1'b0;
    alu_b_imm   = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wsel     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (is_j) begin
          pc_we      = 1'b1;
          pc_sel     = 2'd2;
          next_state = S_IDLE;
        end else if (is_nop || is_bad) begin
          pc_we      = 1'b1;
          illegal    = is_bad;
          next_state = S_IDLE;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op     = ex_op;
        alu_a_zero = ex_a_zero;
        alu_b_imm  = ex_b_imm;
        if (is_beq) begin
          pc_we      = 1'b1;
          pc_sel     = (alu_result == 32'd0) ? 2'd1 : 2'd0;
          next_state = S_IDLE;
        end else if (is_lw || is_sw) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        alu_op     = ex_op;
        alu_a_zero = ex_a_zero;
        alu_b_imm  = ex_b_imm;
        mem_req    = 1'b1;
        mem_we     = is_sw;
        if (mem_ack) begin
          pc_we      = is_sw;
          next_state = is_sw ? S_IDLE : S_WB;
        end
      end
      S_WB: begin
        rf_we      = (dest != 5'd0);
        rf_waddr   = dest;
        rf_wsel    = is_lw;
        pc_we      = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ir      <= 32'd0;
      retired <= 32'd0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && instr_valid) ir <= instr;
      if (pc_we) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and random instructions checked cycle by cycle
// against a per-instruction phase model derived from the instruction class.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] alu_result;
  logic [2:0]  alu_op;
  logic        alu_a_zero, alu_b_imm;
  logic [31:0] imm_ext;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        rf_wsel, mem_req, mem_we, mem_ack, pc_we;
  logic [1:0]  pc_sel;
  logic        illegal;
  logic [31:0] retired;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_result(alu_result), .alu_op(alu_op),
    .alu_a_zero(alu_a_zero), .alu_b_imm(alu_b_imm), .imm_ext(imm_ext),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .mem_req(mem_req),
    .mem_we(mem_we), .mem_ack(mem_ack), .pc_we(pc_we), .pc_sel(pc_sel),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef enum {K_R, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_NOP, K_ILL} kind_e;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_ret = 32'd0;
  logic [5:0]  functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h2b};
  logic [2:0]  fops   [6] = '{3'd1, 3'd2, 3'd6, 3'd3, 3'd4, 3'd5};

  logic [31:0] obs_ctrl;
  assign obs_ctrl = {13'd0, instr_ready, alu_op, alu_a_zero, alu_b_imm, rf_we, rf_waddr,
                     rf_wsel, mem_req, mem_we, pc_we, pc_sel, illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic kind_e classify(input logic [31:0] i);
    if (i == 32'd0) return K_NOP;
    case (i[31:26])
      6'h00: begin
        for (int k = 0; k < 6; k++) if (i[5:0] == functs[k]) return K_R;
        return K_ILL;
      end
      6'h0d: return K_ORI;
      6'h0f: return K_LUI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] pack(input logic rdy, input logic [2:0] op, input logic az,
                                       input logic bi, input logic we, input logic [4:0] wa,
                                       input logic ws, input logic mr, input logic mw,
                                       input logic pw, input logic [1:0] ps, input logic il);
    return {13'd0, rdy, op, az, bi, we, wa, ws, mr, mw, pw, ps, il};
  endfunction

  // Apply one instruction; w = MEM cycles without ack, br = alu_result for beq
  task automatic run_instr(input logic [31:0] ins, input int w, input logic [31:0] br);
    kind_e       k;
    logic [2:0]  op;
    logic        az, bi, ack;
    logic [4:0]  dst;
    logic [31:0] imm, e;
    byte         ph[$];
    int          mcnt;
    k   = classify(ins);
    op  = 3'd0; az = 1'b0; bi = 1'b0;
    dst = (k == K_R) ? ins[15:11] : ins[20:16];
    case (k)
      K_R:         for (int j = 0; j < 6; j++) if (ins[5:0] == functs[j]) op = fops[j];
      K_ORI:       begin op = 3'd3; bi = 1'b1; end
      K_LUI:       begin op = 3'd3; bi = 1'b1; az = 1'b1; end
      K_LW, K_SW:  begin op = 3'd1; bi = 1'b1; end
      K_BEQ:       op = 3'd2;
      default:     op = 3'd0;
    endcase
    if (k == K_LUI)      imm = {ins[15:0], 16'h0};
    else if (k == K_ORI) imm = {16'h0, ins[15:0]};
    else                 imm = {{16{ins[15]}}, ins[15:0]};
    ph.push_back("D");
    if (k != K_J && k != K_NOP && k != K_ILL) ph.push_back("E");
    if (k == K_LW || k == K_SW) for (int j = 0; j <= w; j++) ph.push_back("M");
    if (k == K_R || k == K_ORI || k == K_LUI || k == K_LW) ph.push_back("W");

    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    mem_ack = 1'($urandom); alu_result = $urandom;
    #1;
    chk("idle_ctrl", obs_ctrl, pack(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk("idle_retired", retired, model_ret);
    mcnt = 0;
    foreach (ph[p]) begin
      @(negedge clk);
      instr = $urandom; instr_valid = 1'($urandom);
      ack = (ph[p] == "M") ? (mcnt == w) : 1'($urandom);
      mem_ack = ack;
      alu_result = (ph[p] == "E" && k == K_BEQ) ? br : $urandom;
      #1;
      case (ph[p])
        "D": e = pack(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                      k == K_J || k == K_NOP || k == K_ILL, (k == K_J) ? 2'd2 : 2'd0, k == K_ILL);
        "E": e = pack(1'b0, op, az, bi, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                      k == K_BEQ, (k == K_BEQ && br == 32'd0) ? 2'd1 : 2'd0, 1'b0);
        "M": e = pack(1'b0, op, az, bi, 1'b0, 5'd0, 1'b0, 1'b1, k == K_SW,
                      k == K_SW && ack, 2'd0, 1'b0);
        default: e = pack(1'b0, 3'd0, 1'b0, 1'b0, dst != 5'd0, dst, k == K_LW, 1'b0, 1'b0,
                          1'b1, 2'd0, 1'b0);
      endcase
      chk($sformatf("ctrl_%h_%c%0d", ins, ph[p], p), obs_ctrl, e);
      chk($sformatf("imm_%h_%c%0d", ins, ph[p], p), imm_ext, imm);
      chk($sformatf("retired_%h_%c%0d", ins, ph[p], p), retired, model_ret);
      if (ph[p] == "M") mcnt++;
    end
    model_ret = model_ret + 32'd1;
    instr_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r, s;
    r = $urandom;
    s = $urandom;
    case ($urandom_range(0, 9))
      0, 1: return {6'h00, r[25:11], 5'd0, functs[$urandom_range(0, 5)]};
      2:    return {6'h0d, r[25:0]};
      3:    return {6'h0f, r[25:0]};
      4:    return {6'h23, r[25:0]};
      5:    return {6'h2b, r[25:0]};
      6:    return {6'h04, r[25:0]};
      7:    return {6'h02, r[25:0]};
      8:    return 32'd0;
      default: return (s[0]) ? {6'h08, r[25:0]} : {6'h00, r[25:6], 6'h21};
    endcase
  endfunction

  initial begin
    logic [31:0] ri, rb;
    reset = 1'b1; instr = 32'd0; instr_valid = 1'b0; alu_result = 32'd0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", obs_ctrl, pack(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk("reset_imm", imm_ext, 32'd0);
    chk("reset_retired", retired, 32'd0);
    reset = 1'b0;

    run_instr(32'h00221820, 0, 0);
    run_instr(32'h00221822, 0, 0);
    run_instr(32'h00221824, 0, 0);
    run_instr(32'h00221825, 0, 0);
    run_instr(32'h0022182a, 0, 0);
    run_instr(32'h0022182b, 0, 0);
    run_instr(32'h3421FFFF, 0, 0);
    run_instr(32'h3C011234, 0, 0);
    run_instr(32'h10220003, 0, 32'd0);
    run_instr(32'h10220003, 0, 32'd5);
    run_instr(32'h8C220004, 3, 0);
    run_instr(32'hAC22FFFC, 0, 0);
    run_instr(32'hAC22FFFC, 2, 0);
    run_instr(32'hFC000000, 0, 0);
    run_instr(32'h00221800, 0, 0);
    run_instr(32'h08000010, 0, 0);
    run_instr(32'h00220020, 0, 0);
    run_instr(32'h8C200008, 1, 0);
    run_instr(32'h00000000, 0, 0);

    for (int n = 0; n < 60; n++) begin
      ri = rand_instr();
      rb = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      run_instr(ri, $urandom_range(0, 3), rb);
    end

    // Reset during MEM of lw: request must drop without waiting for a clock edge
    @(negedge clk);
    instr = 32'h8C220004; instr_valid = 1'b1; mem_ack = 1'b0;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_ctrl", obs_ctrl, pack(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
    chk("async_reset_retired", retired, 32'd0);
    model_ret = 32'd0;
    @(negedge clk); reset = 1'b0;
    run_instr(32'h00221820, 0, 0);

    // Counter wrap
    @(negedge clk);
    force dut.retired = 32'hFFFFFFFF;
    #1 release dut.retired;
    model_ret = 32'hFFFFFFFF;
    run_instr(32'h00000000, 0, 0);
    @(negedge clk); #1;
    chk("wrap_retired", retired, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
